// File: rtl/ntt_intt_ip_pkg.sv
// ============================================================================
// Module  : ntt_intt_ip_pkg
// Purpose : Shared op codes, core ctrl bit indices and sequencer state type.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ntt_intt_ip_pkg;

  localparam logic [5:0] NTT  = 6'h01;
  localparam logic [5:0] INTT = 6'h02;

  localparam int CTRL_W          = 10;
  localparam int CTRL_START_FNTT = 0;
  localparam int CTRL_LOAD_F     = 1;
  localparam int CTRL_LOAD_I     = 2;
  localparam int CTRL_READ       = 5;
  localparam int CTRL_START_INTT = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    READ  = 3'd4
  } drv_state_t;

  // Core control word driven while the sequencer sits in state st.
  function automatic logic [CTRL_W-1:0] ctrl_for(input drv_state_t st, input logic intt);
    logic [CTRL_W-1:0] v;
    v = '0;
    case (st)
      LOAD:    v[intt ? CTRL_LOAD_I : CTRL_LOAD_F] = 1'b1;
      START:   v[intt ? CTRL_START_INTT : CTRL_START_FNTT] = 1'b1;
      READ:    v[CTRL_READ] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ntt_stream_fifo.sv
// ============================================================================
// Module  : ntt_stream_fifo
// Purpose : Synchronous FIFO with occupancy count and flush (power-of-two depth).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ntt_stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_pop   = i_pop && (r_cnt != '0);
  assign w_push  = i_push && ((r_cnt != CW'(DEPTH)) || w_pop);
  assign o_data  = r_mem[r_rp];
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !i_clr) begin
      r_mem[r_wp] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ntt_intt_stream_drv.sv
// ============================================================================
// Module  : ntt_intt_stream_drv
// Purpose : Command sequencer that loads, starts and drains the NTT/INTT core.
//           Optional watchdog enabled by defining NTT_STREAM_WATCHDOG_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ntt_intt_stream_drv
  import ntt_intt_ip_pkg::*;
#(
  parameter int N_WORDS     = 128,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [5:0]  cmd_op_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic [9:0]  ctrl_o,
  output logic [31:0] din_o,
  output logic        din_en_o,
  output logic        read_en_o,
  input  logic        gnt_valid_i,
  input  logic [31:0] dout_i,
  input  logic        ip_done_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int CW = $clog2(N_WORDS + 1);
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] c_N_WORDS = CW'(N_WORDS);

  drv_state_t    r_state, w_next;
  logic          r_is_intt;
  logic [CW-1:0] r_wcnt, r_req, r_rcvd;
  logic [FW-1:0] r_outst;
  logic [9:0]    r_ctrl;
  logic [31:0]   r_din;
  logic          r_din_en, r_read_en, r_done, r_err;

  logic          w_cmd_ok, w_cmd_take, w_in_fire, w_gnt_ok, w_gnt_bad;
  logic          w_rd_issue, w_timeout, w_op_intt, w_pop, w_fifo_empty;
  logic [FW-1:0] w_fifo_cnt, w_credit;

  assign w_cmd_ok   = (cmd_op_i == NTT) || (cmd_op_i == INTT);
  assign w_cmd_take = (r_state == IDLE) && cmd_valid_i;
  assign w_in_fire  = in_valid_i && in_ready_o;
  assign w_gnt_ok   = gnt_valid_i && (r_state == READ) && (r_outst != '0);
  assign w_gnt_bad  = gnt_valid_i && !w_gnt_ok;
  assign w_pop      = out_valid_o && out_ready_i;
  // Free slots minus words already in flight; never negative by construction.
  assign w_credit   = FW'(FIFO_DEPTH) - w_fifo_cnt - r_outst;
  assign w_rd_issue = (r_state == READ) && (w_credit != '0) && (r_req != c_N_WORDS);
  assign w_op_intt  = (r_state == IDLE) ? (cmd_op_i == INTT) : r_is_intt;

  assign cmd_ready_o = (r_state == IDLE);
  assign busy_o      = (r_state != IDLE);
  assign in_ready_o  = (r_state == LOAD) && (r_wcnt != c_N_WORDS);
  assign out_valid_o = !w_fifo_empty;
  assign ctrl_o      = r_ctrl;
  assign din_o       = r_din;
  assign din_en_o    = r_din_en;
  assign read_en_o   = r_read_en;
  assign done_o      = r_done;
  assign err_o       = r_err;

`ifdef NTT_STREAM_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_wd;
  logic          w_wd_run;

  assign w_wd_run  = (r_state == WAIT) || (r_state == READ);
  assign w_timeout = w_wd_run && (r_wd == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      r_wd <= '0;
    else if (!w_wd_run || gnt_valid_i || w_next != r_state) r_wd <= '0;
    else                                             r_wd <= r_wd + TW'(1);
  end
`else
  // Without the watchdog the limit is irrelevant and the timeout never fires.
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cmd_valid_i && w_cmd_ok) w_next = LOAD;
      LOAD:    if (r_wcnt == c_N_WORDS) w_next = START;
      START:   w_next = WAIT;
      WAIT:    if (ip_done_i) w_next = READ;
      READ:    if ((r_rcvd == c_N_WORDS) && w_fifo_empty) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_timeout) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_intt <= 1'b0;
      r_ctrl    <= '0;
      r_din     <= '0;
      r_din_en  <= 1'b0;
      r_read_en <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_cmd_take && w_cmd_ok) r_is_intt <= (cmd_op_i == INTT);
      r_ctrl    <= ctrl_for(w_next, w_op_intt);
      if (w_in_fire) r_din <= in_data_i;
      r_din_en  <= w_in_fire;
      r_read_en <= w_rd_issue;
      r_done    <= ((r_state != IDLE) && (w_next == IDLE)) || (w_cmd_take && !w_cmd_ok);
      if (w_gnt_bad || w_timeout || (w_cmd_take && !w_cmd_ok)) r_err <= 1'b1;
      else if (w_cmd_take)                                    r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt  <= '0;
      r_req   <= '0;
      r_rcvd  <= '0;
      r_outst <= '0;
    end else if (r_state == IDLE) begin
      r_wcnt  <= '0;
      r_req   <= '0;
      r_rcvd  <= '0;
      r_outst <= '0;
    end else begin
      if (w_in_fire)  r_wcnt <= r_wcnt + CW'(1);
      if (w_rd_issue) r_req  <= r_req + CW'(1);
      if (w_gnt_ok)   r_rcvd <= r_rcvd + CW'(1);
      case ({w_rd_issue, w_gnt_ok})
        2'b10:   r_outst <= r_outst + FW'(1);
        2'b01:   r_outst <= r_outst - FW'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

  ntt_stream_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_timeout),
    .i_push  (w_gnt_ok),
    .i_data  (dout_i),
    .i_pop   (w_pop),
    .o_data  (out_data_o),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_ntt_intt_stream_drv.sv
// ============================================================================
// Module  : tb_ntt_intt_stream_drv
// Purpose : Directed bench with a small core model for ntt_intt_stream_drv.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ntt_intt_stream_drv;
  import ntt_intt_ip_pkg::*;

  localparam int NW = 8;
  localparam int FD = 4;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [5:0]  cmd_op_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_data_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] out_data_o;
  logic [9:0]  ctrl_o;
  logic [31:0] din_o;
  logic        din_en_o;
  logic        read_en_o;
  logic        gnt_valid_i = 1'b0;
  logic [31:0] dout_i = '0;
  logic        ip_done_i = 1'b0;
  logic        busy_o, done_o, err_o;

  always #5 clk = ~clk;

  ntt_intt_stream_drv #(
    .N_WORDS     (NW),
    .FIFO_DEPTH  (FD),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .ctrl_o      (ctrl_o),
    .din_o       (din_o),
    .din_en_o    (din_en_o),
    .read_en_o   (read_en_o),
    .gnt_valid_i (gnt_valid_i),
    .dout_i      (dout_i),
    .ip_done_i   (ip_done_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Core model: captures loaded words, raises ip_done 20 cycles after start,
  // answers each read_en two cycles later (NTT: x*10, INTT: x+100).
  logic [31:0] mem [NW];
  int          ld_idx = 0, rd_idx = 0, timer = 0;
  bit          m_intt = 1'b0;
  bit          done_en = 1'b1;
  int          inj_req = 0, inj_ack = 0;
  logic [1:0]  p_v = '0;
  logic [31:0] p_d [2];

  always @(negedge clk) begin
    if (!rst_n) begin
      ld_idx = 0; rd_idx = 0; timer = 0; p_v = '0;
      ip_done_i = 1'b0; gnt_valid_i = 1'b0;
    end else begin
      if (din_en_o) begin mem[ld_idx % NW] = din_o; ld_idx++; end
      if (ctrl_o[CTRL_START_FNTT] || ctrl_o[CTRL_START_INTT]) begin
        timer = 20; m_intt = ctrl_o[CTRL_START_INTT]; ld_idx = 0; rd_idx = 0;
      end
      ip_done_i = 1'b0;
      if (timer != 0) begin
        timer--;
        if (timer == 0 && done_en) ip_done_i = 1'b1;
      end
      gnt_valid_i = p_v[1]; dout_i = p_d[1];
      p_v[1] = p_v[0]; p_d[1] = p_d[0];
      p_v[0] = read_en_o;
      p_d[0] = m_intt ? mem[rd_idx % NW] + 32'd100 : mem[rd_idx % NW] * 32'd10;
      if (read_en_o) rd_idx++;
      if (inj_req != inj_ack) begin
        gnt_valid_i = 1'b1; dout_i = 32'hDEAD; inj_ack = inj_req;
      end
    end
  end

  int n_din = 0, n_rd = 0, n_c001 = 0, n_c100 = 0, n_c002 = 0, n_c004 = 0, n_done = 0;
  int cyc = 0, t_start = 0, t_done = 0;
  logic [31:0] got [$];

  always @(negedge clk) begin
    cyc++;
    if (din_en_o)  n_din++;
    if (read_en_o) n_rd++;
    if (ctrl_o == 10'h001) begin n_c001++; t_start = cyc; end
    if (ctrl_o == 10'h100) n_c100++;
    if (ctrl_o == 10'h002) n_c002++;
    if (ctrl_o == 10'h004) n_c004++;
    if (done_o) begin n_done++; t_done = cyc; end
    if (out_valid_o && out_ready_i) got.push_back(out_data_o);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [5:0] op);
    tick(); cmd_valid_i = 1'b1; cmd_op_i = op;
    tick(); cmd_valid_i = 1'b0;
  endtask

  task automatic send_words(input int base, input bit toggle);
    int i = 0;
    int guard = 0;
    bit gap = 1'b0;
    while (i < NW && guard < 200) begin
      tick();
      if (gap) begin
        in_valid_i = 1'b0; gap = 1'b0;
      end else begin
        in_valid_i = 1'b1; in_data_i = 32'(base + i);
        @(negedge clk);
        if (in_ready_o) begin i++; gap = toggle; end
      end
      guard++;
    end
    tick(); in_valid_i = 1'b0;
    check_eq("load_words", 32'(i), 32'(NW));
  endtask

  task automatic wait_done(input int maxc);
    bit ok = 1'b0;
    for (int k = 0; k < maxc && !ok; k++) begin
      @(negedge clk);
      if (done_o) ok = 1'b1;
    end
    check_eq("done_seen", 32'(ok), 32'd1);
    tick(); tick();
  endtask

  task automatic check_results(input int g0, input int base, input bit intt);
    check_eq("res_count", 32'(got.size() - g0), 32'(NW));
    for (int i = 0; i < NW; i++)
      check_eq("res_word", got[g0 + i], intt ? 32'(base + i + 100) : 32'((base + i) * 10));
  endtask

  int b_din, b_rd, b001, b100, b002, b004, b_done, g0;

  task automatic snap();
    b_din = n_din; b_rd = n_rd; b001 = n_c001; b100 = n_c100;
    b002 = n_c002; b004 = n_c004; b_done = n_done; g0 = got.size();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_flags", 32'({cmd_ready_o, busy_o, err_o, done_o, out_valid_o,
                               in_ready_o, din_en_o, read_en_o}), 32'h80);
    check_eq("rst_ctrl", 32'(ctrl_o), 32'h0);
    check_eq("rst_data", out_data_o | din_o, 32'h0);
    tick(); rst_n = 1'b1; tick();

    // NTT, back-to-back input, consumer always ready
    snap();
    send_cmd(NTT); send_words(1, 1'b0); wait_done(300);
    check_eq("ntt_din_en", 32'(n_din - b_din), 32'(NW));
    check_eq("ntt_start_cyc", 32'(n_c001 - b001), 32'd1);
    check_eq("ntt_load_ctrl", 32'(n_c002 - b002 > 0), 32'd1);
    check_eq("ntt_reads", 32'(n_rd - b_rd), 32'(NW));
    check_eq("ntt_done_cnt", 32'(n_done - b_done), 32'd1);
    check_eq("ntt_err", 32'(err_o), 32'd0);
    check_eq("ntt_busy", 32'(busy_o), 32'd0);
    check_results(g0, 1, 1'b0);

    // Stalled consumer: requests stop at FIFO depth; spurious grant dropped
    out_ready_i = 1'b0;
    snap();
    send_cmd(NTT); send_words(1, 1'b0);
    for (int k = 0; k < 300 && (n_rd - b_rd) < FD; k++) tick();
    repeat (10) tick();
    check_eq("stall_reads", 32'(n_rd - b_rd), 32'(FD));
    check_eq("stall_valid", 32'(out_valid_o), 32'd1);
    check_eq("stall_head", out_data_o, 32'd10);
    inj_req++;
    repeat (3) tick();
    check_eq("spur_read_err", 32'(err_o), 32'd1);
    check_eq("stall_head_hold", out_data_o, 32'd10);
    out_ready_i = 1'b1;
    wait_done(300);
    check_eq("stall_reads_all", 32'(n_rd - b_rd), 32'(NW));
    check_eq("err_sticky", 32'(err_o), 32'd1);
    check_results(g0, 1, 1'b0);

    // INTT with in_valid toggling; accepted command clears err
    snap();
    send_cmd(INTT);
    check_eq("intt_err_clr", 32'(err_o), 32'd0);
    send_words(5, 1'b1); wait_done(300);
    check_eq("intt_load_ctrl", 32'(n_c004 - b004 > 0), 32'd1);
    check_eq("intt_no_f_load", 32'(n_c002 - b002), 32'd0);
    check_eq("intt_start_cyc", 32'(n_c100 - b100), 32'd1);
    check_eq("intt_no_fntt", 32'(n_c001 - b001), 32'd0);
    check_results(g0, 5, 1'b1);

    // Unknown op code
    snap();
    send_cmd(6'h3F); tick();
    check_eq("badop_err", 32'(err_o), 32'd1);
    check_eq("badop_busy", 32'(busy_o), 32'd0);
    check_eq("badop_done", 32'(n_done - b_done), 32'd1);

    // Asynchronous reset in the middle of READ
    out_ready_i = 1'b0;
    snap();
    send_cmd(NTT); send_words(1, 1'b0);
    for (int k = 0; k < 300 && (n_rd - b_rd) < 1; k++) tick();
    tick(); #3 rst_n = 1'b0; #1;
    check_eq("arst_flags", 32'({cmd_ready_o, busy_o, err_o, done_o, out_valid_o,
                                in_ready_o, din_en_o, read_en_o}), 32'h80);
    check_eq("arst_ctrl", 32'(ctrl_o), 32'h0);
    out_ready_i = 1'b1;
    tick(); tick(); rst_n = 1'b1; tick();

    // Grant while idle
    inj_req++;
    repeat (3) tick();
    check_eq("spur_idle_err", 32'(err_o), 32'd1);
    check_eq("spur_idle_valid", 32'(out_valid_o), 32'd0);

    // Normal operation after reset
    snap();
    send_cmd(NTT);
    check_eq("post_err_clr", 32'(err_o), 32'd0);
    send_words(3, 1'b0); wait_done(300);
    check_eq("post_done_cnt", 32'(n_done - b_done), 32'd1);
    check_results(g0, 3, 1'b0);

`ifdef NTT_STREAM_WATCHDOG_EN
    // Core never finishes: watchdog aborts TIMEOUT cycles after WAIT entry
    done_en = 1'b0;
    snap();
    send_cmd(NTT); send_words(1, 1'b0); wait_done(300);
    check_eq("wd_latency", 32'(t_done - (t_start + 1)), 32'(TO));
    check_eq("wd_err", 32'(err_o), 32'd1);
    check_eq("wd_busy", 32'(busy_o), 32'd0);
    check_eq("wd_done_cnt", 32'(n_done - b_done), 32'd1);
    done_en = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no end expected end");
    $fatal(1, "bench timeout");
  end

endmodule

`default_nettype wire

// File: doc/ntt_intt_stream_drv.md
Name: ntt_intt_stream_drv

Overview:
- Host-side sequencer; the initiator end of the NTT/INTT core's data interface.
- Accepts one command (NTT or INTT), streams N_WORDS input words into the core, starts the transform, and waits for done.
- Then pulls N_WORDS results using the read_en/gnt_valid handshake and presents them on a valid/ready output stream.
- Sits between a DMA/stream fabric and the core's ctrl/din/dout pins.

Parameters:
- N_WORDS, 128, words loaded and words read back per operation.
- FIFO_DEPTH, 4, output buffer depth (power of two, ≥2).
- TIMEOUT_CYC, 65535, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  high in IDLE only
- cmd_op_i  in  6  operation code: ntt_intt_ip_pkg::NTT or INTT
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  input word accepted when valid&&ready
- in_data_i  in  32  input word
- out_valid_o  out  1  result word valid
- out_ready_i  in  1  result consumer ready
- out_data_o  out  32  result word
- ctrl_o  out  10  core control: bit0 start_fntt, bit1 load_a_f, bit2 load_a_i, bit5 read_a, bit8 start_intt; other bits 0
- din_o  out  32  word to core
- din_en_o  out  1  one-cycle strobe per loaded word
- read_en_o  out  1  one-cycle read request to core
- gnt_valid_i  in  1  core returns one dout word this cycle
- dout_i  in  32  core result word
- ip_done_i  in  1  core transform complete
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse at end of operation
- err_o  out  1  sticky error flag; cleared by the next accepted command

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low. All registers reset asynchronously.
- Reset values: all outputs 0, except cmd_ready_o=1; FIFO empty; state IDLE.
- Registered outputs: ctrl_o, din_o, din_en_o and read_en_o are registered.
- IDLE: on cmd_valid_i, latch op and go to LOAD. Any other op code: set err_o, pulse done_o, stay IDLE.
- LOAD:
  - ctrl_o holds load_a_f (NTT) or load_a_i (INTT). in_ready_o=1.
  - Each handshake registers din_o=in_data_i and pulses din_en_o the following cycle.
  - wcnt counts 0..N_WORDS-1. After word N_WORDS-1 is accepted: in_ready_o=0 the next cycle, then go to START.
- START: exactly one cycle; ctrl_o = start_fntt or start_intt only. Then WAIT.
- WAIT:
  - ctrl_o=0. Go to READ in the cycle after ip_done_i=1.
  - ip_done_i seen in LOAD/START is ignored.
- READ:
  - ctrl_o holds read_a.
  - Credits = FIFO free slots − outstanding requests.
  - read_en_o pulses when credits>0 and requested<N_WORDS. A new request may issue every cycle.
  - Each gnt_valid_i pushes dout_i into the FIFO and decrements outstanding.
  - gnt_valid_i with outstanding==0 sets err_o and drops the word.
  - Leave when received==N_WORDS and the FIFO is empty; pulse done_o for one cycle, then IDLE.
- Output stream:
  - out_valid_o = FIFO not empty. out_data_o = FIFO head, stable while valid && !ready.
  - Simultaneous push and pop in the same cycle is allowed. A full FIFO can never be pushed, by construction of the credits.
- gnt_valid_i outside READ: ignored, and err_o set.
- Reset mid-operation: immediate return to IDLE; FIFO flushed; counters cleared; ctrl_o=0. The core is expected to be reset by the same rst_n.
- Counter widths: $clog2(N_WORDS+1). Credit counter width: $clog2(FIFO_DEPTH+1).

Optional Feature:
- Macro: NTT_STREAM_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in WAIT and READ, and clears on every gnt_valid_i and on state entry.
  - When it reaches TIMEOUT_CYC: set err_o, flush the FIFO, pulse done_o, go to IDLE.
- Undefined: no counter; WAIT and READ wait indefinitely.

Decomposition:
- ntt_intt_ip_pkg holds:
  - the state enum (IDLE, LOAD, START, WAIT, READ);
  - ctrl bit-index constants (CTRL_START_FNTT=0, CTRL_LOAD_F=1, CTRL_LOAD_I=2, CTRL_READ=5, CTRL_START_INTT=8);
  - reuse of the existing NTT/INTT op codes.
- Sub-module ntt_stream_fifo: synchronous FIFO with count, parameterised by width and depth.

Test Plan:
- NTT, N_WORDS=4, inputs 1,2,3,4 with core model returning 10,20,30,40 and ip_done_i 20 cycles after start -> din_en_o pulses 4 times; ctrl_o=0x001 for one cycle; outputs 10,20,30,40; done_o pulses once.
- INTT with in_valid_i toggling every other cycle -> ctrl_o=0x004 during LOAD; exactly one 0x100 start cycle; result order preserved.
- out_ready_i held 0 during READ, FIFO_DEPTH=4 -> read_en_o count stops at 4; no dropped words; after release all N_WORDS delivered.
- Core asserts gnt_valid_i with no request pending -> err_o=1; word dropped; next command clears err_o.
- rst_n low mid-READ -> outputs return to reset values asynchronously; a following command completes normally.
- Watchdog enabled, TIMEOUT_CYC=50, ip_done_i never asserted -> err_o=1 and done_o pulse 50 cycles after WAIT entry; state returns to IDLE.
